// File: rtl/adder_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_sched
// Purpose  : Round-robin scheduler sharing one registered W-bit adder among
//            NREQ requesters. One operation runs at a time through the states
//            IDLE -> CALC -> RESP. A requester is granted, its operands and
//            the global saturate flag are latched, the add is performed, and
//            the result is returned with a one-cycle done pulse.
// Ports    : clk     - clock, rising edge
//            rst     - synchronous active-high reset
//            req     - per-requester request level
//            a_flat  - operand A per requester, requester i at [i*W +: W]
//            b_flat  - operand B per requester, same packing
//            sat     - saturate mode, sampled at grant time
//            gnt     - registered one-hot grant, held through RESP
//            done    - one-hot completion pulse, high only in RESP
//            sum     - registered result, held until the next CALC
//            cout    - registered carry of the unsaturated add
//            busy    - high whenever the scheduler is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module adder_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  input  logic              sat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      sum,
  output logic              cout,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);

  typedef logic [PW-1:0] idx_t;
  typedef logic [PW:0]   idx_ext_t;

  localparam idx_ext_t C_NREQ     = idx_ext_t'(NREQ);
  localparam idx_t     C_LAST_IDX = idx_t'(NREQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  idx_t            ptr_q, ptr_d;
  idx_t            idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sat_q, sat_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: first set request scanning ptr, ptr+1, ... with
  // wrap-around. The candidate index is kept one bit wider so the modulo
  // reduction works for any NREQ, not only powers of two.
  // --------------------------------------------------------------------------
  logic     sel_found;
  idx_t     sel_idx;
  idx_ext_t cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + idx_ext_t'(k);
      if (cand >= C_NREQ) begin
        cand = cand - C_NREQ;
      end
      if (!sel_found && req[cand[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [NREQ-1:0] sel_onehot;
  logic [W:0]      add_full;

  assign a_sel      = a_flat[int'(sel_idx)*W +: W];
  assign b_sel      = b_flat[int'(sel_idx)*W +: W];
  assign sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
  assign add_full   = {1'b0, a_q} + {1'b0, b_q};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (sel_found) begin
          idx_d   = sel_idx;
          gnt_d   = sel_onehot;
          a_d     = a_sel;
          b_d     = b_sel;
          sat_d   = sat;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        // Carry is always reported from the raw add, even when saturating.
        sum_d   = (sat_q && add_full[W]) ? {W{1'b1}} : add_full[W-1:0];
        cout_d  = add_full[W];
        state_d = S_RESP;
      end

      S_RESP: begin
        // Advance past the winner so every other pending requester is
        // considered before the winner can be picked again.
        ptr_d   = (idx_q == C_LAST_IDX) ? '0 : idx_q + idx_t'(1);
        gnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = (state_q == S_RESP) ? gnt_q : '0;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q != S_IDLE);

endmodule
`default_nettype wire
